// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and payload type for the UART frame arbiter.
package uart_frame_pkg;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned DATA_W    = 24;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned MODE_W    = 6;
    localparam int unsigned FRAME_LEN = 7;

    localparam logic [7:0] SOF = 8'hFF;
    localparam logic [7:0] EOF = 8'hAA;

    localparam logic [IDX_W-1:0] BI_SOF   = 3'd0;
    localparam logic [IDX_W-1:0] BI_ADDR  = 3'd1;
    localparam logic [IDX_W-1:0] BI_MODE  = 3'd2;
    localparam logic [IDX_W-1:0] BI_D_HI  = 3'd3;
    localparam logic [IDX_W-1:0] BI_D_MID = 3'd4;
    localparam logic [IDX_W-1:0] BI_D_LO  = 3'd5;
    localparam logic [IDX_W-1:0] BI_EOF   = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FGAP = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic [MODE_W-1:0] mode;
    } payload_t;

    // Byte at position idx of the telemetry frame built from payload p.
    function automatic logic [7:0] frame_byte(input payload_t p, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            BI_SOF:   b = SOF;
            BI_ADDR:  b = {6'b0, p.addr};
            BI_MODE:  b = {2'b0, p.mode};
            BI_D_HI:  b = p.data[23:16];
            BI_D_MID: b = p.data[15:8];
            BI_D_LO:  b = p.data[7:0];
            default:  b = EOF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin picker: first set req at or after ptr (wrapping); ptr moves past the winner on adv.
module uart_rr_arbiter
    import uart_frame_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [NREQ-1:0]  req,
    input  logic             adv,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return PTR_W'(sum % NREQ);
    endfunction

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_vld && req[wrap_add(ptr_q, k)]) begin
                gnt_idx = wrap_add(ptr_q, k);
                gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv && gnt_vld) begin
            ptr_d = wrap_add(gnt_idx, 1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Shares one byte-level uart_send among NREQ requesters: round-robin grant, payload latch,
// and paced serialisation of the 7-byte telemetry frame FF, addr, mode, D2, D1, D0, AA.
module uart_frame_arbiter
    import uart_frame_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned BYTE_GAP  = 12000,
    parameter int unsigned FRAME_GAP = 10000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NREQ-1:0]          req,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    input  logic [ADDR_W*NREQ-1:0]   req_addr,
    input  logic [MODE_W*NREQ-1:0]   req_mode,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic                     uart_en,
    output logic [7:0]               uart_din
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_GAP - 1);
    localparam logic [CNT_W-1:0] FGAP_LAST = CNT_W'(FRAME_GAP - 1);

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    payload_t         pl_q,       pl_d;
    logic [PTR_W-1:0] win_q,      win_d;
    logic [NREQ-1:0]  gnt_q,      gnt_d;
    logic [NREQ-1:0]  done_q,     done_d;
    logic             busy_q,     busy_d;
    logic             uart_en_q,  uart_en_d;
    logic [7:0]       uart_din_q, uart_din_d;

    logic [PTR_W-1:0] arb_idx;
    logic             arb_vld;
    logic             arb_adv;
    payload_t         req_pl [NREQ];

    uart_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (req),
        .adv     (arb_adv),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Slice the flat request buses into one payload per requester.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_pl[i].data = req_data[i*DATA_W +: DATA_W];
            req_pl[i].addr = req_addr[i*ADDR_W +: ADDR_W];
            req_pl[i].mode = req_mode[i*MODE_W +: MODE_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        pl_d       = pl_q;
        win_d      = win_q;
        gnt_d      = '0;
        done_d     = '0;
        busy_d     = busy_q;
        uart_en_d  = 1'b0;
        uart_din_d = uart_din_q;
        arb_adv    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    pl_d          = req_pl[arb_idx];
                    win_d         = arb_idx;
                    gnt_d[arb_idx] = 1'b1;
                    busy_d        = 1'b1;
                    arb_adv       = 1'b1;
                    byte_idx_d    = '0;
                    cnt_d         = '0;
                    state_d       = SEND;
                end
            end

            // Byte slot: data at cnt 0, strobe at cnt 1, strobe released by the default.
            SEND: begin
                if (cnt_q == CNT_W'(0)) begin
                    uart_din_d = frame_byte(pl_q, byte_idx_q);
                end
                if (cnt_q == CNT_W'(1)) begin
                    uart_en_d = 1'b1;
                end
                if (cnt_q == BYTE_LAST) begin
                    cnt_d = '0;
                    if (byte_idx_q == BI_EOF) begin
                        done_d[win_q] = 1'b1;
                        if (FRAME_GAP == 0) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = FGAP;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FGAP: begin
                if (cnt_q == FGAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            pl_q       <= '0;
            win_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            uart_en_q  <= 1'b0;
            uart_din_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            pl_q       <= pl_d;
            win_q      <= win_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            uart_en_q  <= uart_en_d;
            uart_din_q <= uart_din_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign uart_en  = uart_en_q;
    assign uart_din = uart_din_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Self-checking bench: frame-timeline reference model plus directed literal checks.
module tb_uart_frame_arbiter;

    localparam int NREQ  = 4;
    localparam int BG    = 8;
    localparam int FG    = 4;
    localparam int TOTAL = 3800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req0;
    logic [95:0] req_data;
    logic [7:0]  req_addr;
    logic [23:0] req_mode;
    logic [3:0]  gnt, done, gnt0, done0;
    logic        busy, uart_en, busy0, uart_en0;
    logic [7:0]  uart_din, uart_din0;

    logic [23:0] pd [NREQ];
    logic [1:0]  pa [NREQ];
    logic [5:0]  pm [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*24 +: 24] = pd[i];
            req_addr[i*2 +: 2]   = pa[i];
            req_mode[i*6 +: 6]   = pm[i];
        end
    end

    uart_frame_arbiter #(.NREQ(4), .BYTE_GAP(BG), .FRAME_GAP(FG)) dut (
        .sys_clk(clk), .sys_rst(rst_n), .req(req), .req_data(req_data),
        .req_addr(req_addr), .req_mode(req_mode), .gnt(gnt), .done(done),
        .busy(busy), .uart_en(uart_en), .uart_din(uart_din));

    uart_frame_arbiter #(.NREQ(4), .BYTE_GAP(BG), .FRAME_GAP(0)) dut0 (
        .sys_clk(clk), .sys_rst(rst_n), .req(req0), .req_data(req_data),
        .req_addr(req_addr), .req_mode(req_mode), .gnt(gnt0), .done(done0),
        .busy(busy0), .uart_en(uart_en0), .uart_din(uart_din0));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one active frame described by its grant cycle and latched payload.
    bit          in_rst = 1'b1;
    bit          have_frame = 1'b0;
    int          free_at = 0;
    int          g = 0;
    int          win = 0;
    int          ptr = 0;
    logic [23:0] m_data;
    logic [1:0]  m_addr;
    logic [5:0]  m_mode;
    logic [7:0]  pre_din = 8'h00;

    // Directed-check bookkeeping.
    logic [7:0] exp_a [7];
    logic [7:0] cap [8];
    int capn = 0, ga = -1, da = -1, fa = -1;
    int g0_c [2];
    int g0_n = 0, b0_low = 0;
    int gq [$];
    bit d_rst_done = 1'b0, d_first_seen = 1'b0;
    int d_rst_at = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int pick(input logic [3:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_byte(input int k);
        case (k)
            0: return 8'hFF;
            1: return {6'b0, m_addr};
            2: return {2'b0, m_mode};
            3: return m_data[23:16];
            4: return m_data[15:8];
            5: return m_data[7:0];
            default: return 8'hAA;
        endcase
    endfunction

    task automatic check_outputs();
        logic [3:0] eg, ed;
        logic       eb, ee;
        logic [7:0] edin;
        int off;
        eg = '0; ed = '0; eb = 1'b0; ee = 1'b0; edin = pre_din;
        if (have_frame) begin
            off = cyc - g;
            if (off == 0) eg = 4'(32'd1 << win);
            if (off == 7*BG) ed = 4'(32'd1 << win);
            eb = (off < 7*BG + FG);
            ee = (off >= 2) && (off <= 2 + 6*BG) && ((off - 2) % BG == 0);
            if (off == 0) edin = pre_din;
            else if (off <= 7*BG) edin = exp_byte((off - 1) / BG);
            else edin = 8'hAA;
        end
        chk("gnt", gnt, eg);
        chk("done", done, ed);
        chk("busy", busy, eb);
        chk("uart_en", uart_en, ee);
        chk("uart_din", uart_din, edin);
        chk("gnt_onehot0", $onehot0(gnt), 1'b1);
        chk("done_onehot0", $onehot0(done), 1'b1);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            in_rst = 1'b1; have_frame = 1'b0; ptr = 0; pre_din = 8'h00; free_at = 0;
        end else begin
            if (in_rst) begin
                in_rst = 1'b0;
                free_at = cyc;
            end
            if (cyc >= free_at && req != 4'b0) begin
                win = pick(req);
                if (have_frame) pre_din = 8'hAA;
                g = cyc + 1;
                m_data = pd[win]; m_addr = pa[win]; m_mode = pm[win];
                ptr = (win + 1) % NREQ;
                have_frame = 1'b1;
                free_at = g + 7*BG + FG;
            end
        end
    endtask

    task automatic monitors();
        if (cyc < 200) begin
            if (uart_en && capn < 8) begin cap[capn] = uart_din; capn++; end
            if (gnt[2] && ga < 0) ga = cyc;
            if (done[2] && da < 0) da = cyc;
            if (da >= 0 && fa < 0 && !busy) fa = cyc;
            if (gnt0 != 4'b0) begin
                chk("fg0_gnt_index", gnt0, 4'b1000);
                if (g0_n < 2) g0_c[g0_n] = cyc;
                g0_n++;
            end
            if (g0_n == 1 && !busy0) b0_low++;
        end
        if (cyc == 199) begin
            chk("a_en_count", capn, 7);
            for (int k = 0; k < 7; k++) chk("a_byte", cap[k], exp_a[k]);
            chk("a_done_latency", da - ga, 56);
            chk("a_busy_tail", fa - da, FG);
            chk("fg0_grants_seen", (g0_n >= 2), 1'b1);
            chk("fg0_regrant_gap", g0_c[1] - g0_c[0], 7*BG + 1);
            chk("fg0_busy_low", b0_low, 1);
        end
        if (cyc > 203 && cyc < 600 && gnt != 4'b0) gq.push_back(oh_idx(gnt));
        if (cyc == 599) begin
            int exp_b [6];
            exp_b = '{0, 1, 3, 0, 1, 3};
            chk("b_grant_count", (gq.size() >= 6), 1'b1);
            for (int k = 0; k < 6 && k < gq.size(); k++) chk("b_grant_order", gq[k], exp_b[k]);
            for (int k = 1; k < gq.size(); k++) chk("b_no_repeat", (gq[k] != gq[k-1]), 1'b1);
        end
        if (d_rst_done && !d_first_seen && gnt != 4'b0) begin
            d_first_seen = 1'b1;
            chk("d_ptr_restart_winner", oh_idx(gnt), 0);
        end
    endtask

    task automatic random_drive();
        if (cyc == 2000) begin rst_n = 1'b0; return; end
        if (cyc == 2002) rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (have_frame && cyc == g && i == win) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) begin
            int j;
            j = $urandom_range(0, NREQ - 1);
            pd[j] = 24'($urandom);
            pa[j] = 2'($urandom);
            pm[j] = 6'($urandom);
        end
    endtask

    task automatic drive();
        if (cyc == 3) begin
            rst_n = 1'b1; req = 4'b0100;
            pd[2] = 24'h123456; pa[2] = 2'b10; pm[2] = 6'h15;
        end else if (cyc > 3 && cyc < 200) begin
            if (have_frame && cyc == g) req[win] = 1'b0;
        end else if (cyc == 200) begin
            rst_n = 1'b0; req = 4'b1011;
            for (int i = 0; i < NREQ; i++) begin
                pd[i] = 24'($urandom); pa[i] = 2'($urandom); pm[i] = 6'($urandom);
            end
        end else if (cyc == 203) begin
            rst_n = 1'b1;
        end else if (cyc > 203 && cyc < 600) begin
            if (have_frame && cyc == g) pd[win] = 24'hFFFFFF;
        end else if (cyc == 600) begin
            req = 4'b0001; pd[0] = 24'($urandom);
        end else if (cyc > 600 && cyc < 800) begin
            if (!d_rst_done && have_frame && g > 600 && cyc == g + 2 + 3*BG) begin
                rst_n = 1'b0; d_rst_done = 1'b1; d_rst_at = cyc;
                #1;
                chk("d_rst_uart_en", uart_en, 1'b0);
                chk("d_rst_uart_din", uart_din, 8'h00);
                chk("d_rst_busy", busy, 1'b0);
            end else if (d_rst_done && !rst_n && cyc == d_rst_at + 3) begin
                rst_n = 1'b1; req = 4'b1111;
            end else if (have_frame && cyc == g) begin
                req[win] = 1'b0;
            end
        end else if (cyc >= 800) begin
            random_drive();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0;
        req0  = 4'b1000;
        for (int i = 0; i < NREQ; i++) begin
            pd[i] = '0; pa[i] = '0; pm[i] = '0;
        end
        exp_a = '{8'hFF, 8'h02, 8'h15, 8'h12, 8'h34, 8'h56, 8'hAA};
        while (cyc < TOTAL) begin
            @(negedge clk);
            check_outputs();
            monitors();
            drive();
            model_step();
            cyc++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_arbiter.md
Name: uart_frame_arbiter

Overview:
- Shares one byte-level UART sender (uart_send: rising-edge-triggered uart_en plus uart_din) among NREQ frame requesters.
- Grants one requester at a time, round-robin, and latches its payload.
- Serialises the standard 7-byte telemetry frame FF, addr, mode, D[23:16], D[15:8], D[7:0], AA with fixed byte pacing.
- Sits between the measurement/control channels and the single uart_send instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BYTE_GAP, 12000, sys_clk cycles per byte slot; must be >= one UART character time and >= 4.
- FRAME_GAP, 10000, idle cycles after each frame before the next arbitration; 0 allowed.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-low.
- req  in  NREQ  level request per requester; held until the matching gnt.
- req_data  in  24*NREQ  payload D; requester i occupies bits [24i+23:24i].
- req_addr  in  2*NREQ  address; requester i occupies [2i+1:2i].
- req_mode  in  6*NREQ  Mod_SEL; requester i occupies [6i+5:6i].
- gnt  out  NREQ  one-cycle pulse; payload of that requester has been latched.
- done  out  NREQ  one-cycle pulse when that requester's last byte slot ends.
- busy  out  1  high from grant until return to IDLE.
- uart_en  out  1  to uart_send.uart_en.
- uart_din  out  8  to uart_send.uart_din.

Behaviour:
- Reset values: all outputs 0; uart_din 8'h00; state IDLE; RR pointer 0; byte_idx 0; cnt 0.
- Reset mid-frame aborts immediately. No partial-frame resume.
- States: IDLE -> SEND -> FGAP -> IDLE.
- IDLE:
  - If any req bit is high, the arbiter picks the first set bit at or after ptr, wrapping modulo NREQ. Call it w.
  - At that same edge: latch frame bytes from w; gnt[w] <= 1 for exactly one cycle; busy <= 1; ptr <= (w+1) mod NREQ; byte_idx <= 0; cnt <= 0; enter SEND.
  - If no req bit is high, stay in IDLE.
- Frame bytes, byte_idx 0..6: 8'hFF, {6'b0,addr}, {2'b0,mode}, D[23:16], D[15:8], D[7:0], 8'hAA.
- Payload is sampled only at grant. Later changes on req_*, or req dropping, do not affect the frame in flight.
- SEND: cnt runs 0..BYTE_GAP-1 within each byte slot.
  - cnt==0 edge: uart_din <= frame[byte_idx]. It stays stable for the rest of the slot.
  - cnt==1 edge: uart_en <= 1.
  - cnt==2 edge: uart_en <= 0. uart_en is therefore a single-cycle pulse, one cycle after uart_din is valid.
  - cnt==BYTE_GAP-1 with byte_idx<6: byte_idx+1, cnt <= 0.
  - cnt==BYTE_GAP-1 with byte_idx==6: done[w] pulses one cycle; cnt <= 0; enter FGAP, or IDLE directly if FRAME_GAP==0.
- FGAP: cnt counts 0..FRAME_GAP-1, then state IDLE with busy <= 0. uart_din holds 8'hAA.
- Latency: req seen in IDLE at edge t gives gnt high in cycle t+1, uart_din=FF from t+2, first uart_en high in cycle t+3. Frame duration is 7*BYTE_GAP cycles.
- req arriving during SEND/FGAP waits. There is no pre-emption and no queuing beyond the req level.
- Fairness: a requester that keeps req high cannot win twice in a row while another bit is set.
- Counters: cnt is 16 bits; BYTE_GAP and FRAME_GAP must be <= 65535. byte_idx is 3 bits. ptr is clog2(NREQ) bits, wrapping to 0 after NREQ-1.
- gnt and done are onehot0 at all times.

Decomposition:
- Package uart_frame_pkg holds: SOF=8'hFF, EOF=8'hAA, FRAME_LEN=7, state encodings (IDLE, SEND, FGAP), and byte-index constants.
- Sub-module uart_rr_arbiter:
  - Ports: sys_clk, sys_rst, req[NREQ], adv, gnt_idx, gnt_vld.
  - Combinational pick from ptr; ptr update on adv.
- The top handles the FSM, payload latch, pacing counter and mux.

Test Plan:
- Single request: NREQ=4, BYTE_GAP=8, FRAME_GAP=4; req[2] with data 0x123456, addr 2'b10, mode 6'h15 -> gnt[2] 1 cycle; uart_en pulses 7 times, 8 cycles apart; uart_din sequence FF,02,15,12,34,56,AA; done[2] after 56 cycles; busy low 4 cycles later.
- Contention: req=4'b1011 held continuously from reset -> grant order 0,1,3,0,1,3; never two consecutive grants to the same index.
- Payload change: after gnt[1], change req_data[1] to 0xFFFFFF -> frame in flight still carries the original bytes.
- Reset mid-frame: assert sys_rst low during byte 3 -> uart_en=0, uart_din=00, busy=0 immediately; after release, req[0] yields a complete fresh frame and ptr restarts at 0.
- FRAME_GAP=0 with back-to-back req[3] -> next gnt[3] arrives the cycle after IDLE is re-entered; busy falls for exactly 1 cycle.
- Pointer wrap: NREQ=4, req=4'b1001, ptr=3 after grant to 2 -> winner 3, then 0, then 3.
